// File: rtl/fp32_pkg.sv
// -----------------------------------------------------------------------------
// fp32_pkg
//   Shared FP32 definitions for the single-precision datapath (multiplier,
//   int->FP32 converter and downstream stages).
//   Contents:
//     BIAS, LATENCY, EXP_MAX, QNAN   numeric constants
//     fp32_t                         packed {sign, exp[7:0], man[22:0]} view
//     op_class_t                     operand-pair class resolved in S1
//     is_special / is_zero           field tests (exp all-ones / exp zero, DAZ)
// -----------------------------------------------------------------------------
package fp32_pkg;

  localparam int          BIAS    = 127;
  localparam int          LATENCY = 3;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  // How the product of an operand pair is formed in the pack stage.
  typedef enum logic [1:0] {
    CLS_FINITE = 2'd0,  // both operands normal: full multiply/round path
    CLS_ZERO   = 2'd1,  // at least one operand zero (incl. denormals)
    CLS_INF    = 2'd2,  // infinite result without exception
    CLS_EXC    = 2'd3   // exceptional operand combination
  } op_class_t;

  function automatic logic is_special(fp32_t x);
    return x.exp == EXP_MAX;
  endfunction

  // Denormals-are-zero: an exponent field of 0 means zero regardless of man.
  function automatic logic is_zero(fp32_t x);
    return x.exp == 8'd0;
  endfunction

endpackage

// File: rtl/fp32_round_rne.sv
// -----------------------------------------------------------------------------
// fp32_round_rne
//   Combinational round-to-nearest-even of a 23-bit mantissa fraction given
//   its guard and sticky bits. Shared with the int->FP32 converter.
//   Ports:
//     m          in   23  fraction bits before rounding
//     g          in   1   guard bit (first bit below m[0])
//     s          in   1   sticky bit (OR of all bits below the guard)
//     m_rounded  out  23  fraction after rounding
//     carry      out  1   rounding overflowed the fraction (caller bumps exp)
// -----------------------------------------------------------------------------
module fp32_round_rne (
  input  logic [22:0] m,
  input  logic        g,
  input  logic        s,
  output logic [22:0] m_rounded,
  output logic        carry
);

  logic up;

  // Round up above half, or exactly at half when m is odd (ties to even).
  assign up = g & (s | m[0]);

  assign {carry, m_rounded} = {1'b0, m} + {23'd0, up};

endmodule

// File: rtl/fp32_mul_pipeline.sv
// -----------------------------------------------------------------------------
// fp32_mul_pipeline
//   3-stage pipelined FP32 multiplier, result = a * b, with round-to-nearest-
//   even, flush-to-zero and denormals-are-zero.
//     S1 unpack   : sign, operand class, 48-bit mantissa product, biased esum
//     S2 normalise: select 23-bit fraction, guard and sticky; adjust exponent
//     S3 round    : RNE, overflow/underflow detection, pack; drives outputs
//   Ports:
//     clk, rst            clock; synchronous active-high reset
//     in_valid/in_ready   input handshake for operands a, b
//     a, b                FP32 operands
//     out_valid/out_ready output handshake for result and flags
//     result              FP32 product
//     Exception           special operand combination
//     Overflow            finite product too large; result = +/-Inf
//     Underflow           nonzero product below normal range; result = +/-0
//   Configuration macro: FP32_MUL_IEEE_SPECIALS_EN
//     defined   : NaN or Inf*0 -> QNAN with Exception; Inf*finite -> +/-Inf
//     undefined : any operand with exp=FF -> +/-0 with Exception
// -----------------------------------------------------------------------------
module fp32_mul_pipeline
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        Exception,
  output logic        Overflow,
  output logic        Underflow
);

  // Handshake: a word moves across an interface on a rising edge where its
  // valid and ready are both high. valid never depends on ready. The whole
  // pipe shifts by one stage whenever the output register is empty or is
  // being drained (adv); bubbles travel with the data and are not collapsed,
  // so when adv is low every stage, including result and flags, holds.
  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !rst;

  // ---------------------------------------------------------------------------
  // S1: unpack
  // ---------------------------------------------------------------------------
  fp32_t       op_a, op_b;
  logic        a_zero, b_zero, a_spec, b_spec;
  op_class_t   cls_d;
  logic [47:0] prod_d;
  logic [9:0]  esum_d;

  assign op_a   = a;
  assign op_b   = b;
  assign a_zero = is_zero(op_a);
  assign b_zero = is_zero(op_b);
  assign a_spec = is_special(op_a);
  assign b_spec = is_special(op_b);

  assign prod_d = {24'd0, 1'b1, op_a.man} * {24'd0, 1'b1, op_b.man};
  // Two's-complement 10-bit exponent; the range -125..381 cannot wrap.
  assign esum_d = {2'b00, op_a.exp} + {2'b00, op_b.exp} - 10'(BIAS);

`ifdef FP32_MUL_IEEE_SPECIALS_EN
  logic a_nan, b_nan;

  assign a_nan = a_spec && (op_a.man != 23'd0);
  assign b_nan = b_spec && (op_b.man != 23'd0);

  always_comb begin
    cls_d = CLS_FINITE;
    if (a_nan || b_nan || (a_spec && b_zero) || (b_spec && a_zero)) begin
      cls_d = CLS_EXC;
    end else if (a_spec || b_spec) begin
      cls_d = CLS_INF;
    end else if (a_zero || b_zero) begin
      cls_d = CLS_ZERO;
    end
  end
`else
  always_comb begin
    cls_d = CLS_FINITE;
    if (a_spec || b_spec) begin
      cls_d = CLS_EXC;
    end else if (a_zero || b_zero) begin
      cls_d = CLS_ZERO;
    end
  end
`endif

  logic        s1_valid;
  logic        s1_sign;
  op_class_t   s1_cls;
  logic [47:0] s1_prod;
  logic [9:0]  s1_esum;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls   <= CLS_ZERO;
      s1_prod  <= '0;
      s1_esum  <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_sign  <= op_a.sign ^ op_b.sign;
      s1_cls   <= cls_d;
      s1_prod  <= prod_d;
      s1_esum  <= esum_d;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: normalise. The product of two [1,2) mantissas lies in [1,4), so at
  // most a one-bit shift is needed.
  // ---------------------------------------------------------------------------
  logic [22:0] norm_m;
  logic        norm_g, norm_s;
  logic [9:0]  norm_exp;

  always_comb begin
    if (s1_prod[47]) begin
      norm_m   = s1_prod[46:24];
      norm_g   = s1_prod[23];
      norm_s   = |s1_prod[22:0];
      norm_exp = s1_esum + 10'd1;
    end else begin
      norm_m   = s1_prod[45:23];
      norm_g   = s1_prod[22];
      norm_s   = |s1_prod[21:0];
      norm_exp = s1_esum;
    end
  end

  logic        s2_valid;
  logic        s2_sign;
  op_class_t   s2_cls;
  logic [22:0] s2_m;
  logic        s2_g, s2_s;
  logic [9:0]  s2_exp;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_cls   <= CLS_ZERO;
      s2_m     <= '0;
      s2_g     <= 1'b0;
      s2_s     <= 1'b0;
      s2_exp   <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_cls   <= s1_cls;
      s2_m     <= norm_m;
      s2_g     <= norm_g;
      s2_s     <= norm_s;
      s2_exp   <= norm_exp;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: round and pack
  // ---------------------------------------------------------------------------
  logic [22:0] m_rnd;
  logic        rnd_carry;
  logic [9:0]  exp_r;
  logic [31:0] result_d;
  logic        exc_d, ovf_d, unf_d;

  fp32_round_rne u_round (
    .m         (s2_m),
    .g         (s2_g),
    .s         (s2_s),
    .m_rounded (m_rnd),
    .carry     (rnd_carry)
  );

  // A rounding carry leaves the fraction at zero and bumps the exponent.
  assign exp_r = s2_exp + {9'd0, rnd_carry};

  always_comb begin
    result_d = {s2_sign, 31'd0};
    exc_d    = 1'b0;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    case (s2_cls)
      CLS_EXC: begin
`ifdef FP32_MUL_IEEE_SPECIALS_EN
        result_d = QNAN;
`else
        result_d = {s2_sign, 31'd0};
`endif
        exc_d    = 1'b1;
      end
      CLS_INF: begin
        result_d = {s2_sign, EXP_MAX, 23'd0};
      end
      CLS_ZERO: begin
        result_d = {s2_sign, 31'd0};
      end
      default: begin
        // exp_r[9] set means a negative exponent.
        if (!exp_r[9] && (exp_r >= 10'd255)) begin
          result_d = {s2_sign, EXP_MAX, 23'd0};
          ovf_d    = 1'b1;
        end else if (exp_r[9] || (exp_r == 10'd0)) begin
          result_d = {s2_sign, 31'd0};
          unf_d    = 1'b1;
        end else begin
          result_d = {s2_sign, exp_r[7:0], m_rnd};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      Exception <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid;
      // Bubbles leave the last result in place; it is qualified by out_valid.
      if (s2_valid) begin
        result    <= result_d;
        Exception <= exc_d;
        Overflow  <= ovf_d;
        Underflow <= unf_d;
      end
    end
  end

endmodule
